// File: rtl/rectverify.sv
// rectverify: rectangular frame-buffer read-back checker.
// Reads an XLEN x YLEN window one word per request/ack transaction and compares each word
// with the 18-bit LFSR sequence written by the rectangular fill block.
// Optional feature macro: RECTVERIFY_ERRADDR_EN builds the first-mismatch capture registers
// (err_addr / err_data); without it both outputs are tied to zero.
module rectverify #(
  parameter int unsigned AN   = 24,
  parameter int unsigned DN   = 16,
  parameter int unsigned BASE = 0,
  parameter int unsigned XN   = 8,
  parameter int unsigned YN   = 8,
  parameter int unsigned LS   = 480,
  parameter int unsigned XOFF = 0,
  parameter int unsigned YOFF = 0,
  parameter int unsigned XLEN = 16,
  parameter int unsigned YLEN = 16
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  output logic [AN-1:0] addr,
  output logic          req,
  output logic          wr,
  input  logic          ack,
  input  logic [DN-1:0] rdata,
  input  logic          start,
  output logic          active,
  output logic          done,
  output logic          pass,
  output logic [15:0]   errors,
  output logic [AN-1:0] err_addr,
  output logic [DN-1:0] err_data
);

  // First word of the window; all address arithmetic wraps at AN bits.
  localparam logic [AN-1:0] RELOAD = AN'(BASE + YOFF * LS + XOFF);
  localparam logic [AN-1:0] STRIDE = AN'(LS);
  localparam logic [XN-1:0] XLAST  = XN'(XLEN - 1);
  localparam logic [YN-1:0] YLAST  = YN'(YLEN - 1);

  typedef enum logic [1:0] {StIdle, StReq, StNext} state_t;

  state_t        r_state;
  logic [AN-1:0] r_addr;
  logic [AN-1:0] r_line;
  logic [XN-1:0] r_x;
  logic [YN-1:0] r_y;
  logic [17:0]   r_lfsr;
  logic          r_req;
  logic          r_active;
  logic          r_done;
  logic          r_pass;
  logic [15:0]   r_errors;

  logic [DN-1:0] w_expected;
  logic          w_mismatch;
  logic [17:0]   w_lfsr_next;
  logic [AN-1:0] w_line_next;
  logic          w_last_x;
  logic          w_last_y;

  // Expected word, mismatch detect and next-state helpers.
  always_comb begin
    w_expected  = r_lfsr[17 -: DN];
    w_mismatch  = (rdata != w_expected);
    w_lfsr_next = {r_lfsr[16:0], ~r_lfsr[17] ^ r_lfsr[10]};
    w_line_next = r_line + STRIDE;
    w_last_x    = (r_x == XLAST);
    w_last_y    = (r_y == YLAST);
  end

  // Main sequencer: start, request/ack handshake, compare, window traversal.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= StIdle;
      r_addr   <= RELOAD;
      r_line   <= RELOAD;
      r_x      <= '0;
      r_y      <= '0;
      r_lfsr   <= '0;
      r_req    <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_errors <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_addr   <= RELOAD;
            r_line   <= RELOAD;
            r_x      <= '0;
            r_y      <= '0;
            r_lfsr   <= '0;
            r_errors <= '0;
            r_pass   <= 1'b0;
            r_active <= 1'b1;
            r_req    <= 1'b1;
            r_state  <= StReq;
          end
        end
        StReq: begin
          if (ack) begin
            r_req   <= 1'b0;
            r_state <= StNext;
            if (w_mismatch && (r_errors != 16'hFFFF)) begin
              r_errors <= r_errors + 16'd1;
            end
          end
        end
        StNext: begin
          r_lfsr <= w_lfsr_next;
          if (w_last_x) begin
            r_x    <= '0;
            r_y    <= r_y + YN'(1);
            r_line <= w_line_next;
            r_addr <= w_line_next;
          end else begin
            r_x    <= r_x + XN'(1);
            r_addr <= r_addr + AN'(1);
          end
          if (w_last_x && w_last_y) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_pass   <= (r_errors == 16'd0);
            r_state  <= StIdle;
          end else begin
            r_req   <= 1'b1;
            r_state <= StReq;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef RECTVERIFY_ERRADDR_EN
  logic [AN-1:0] r_err_addr;
  logic [DN-1:0] r_err_data;

  // Capture address and data of the first mismatching word of a pass.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      r_err_addr <= '0;
      r_err_data <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_err_addr <= '0;
      r_err_data <= '0;
    end else if ((r_state == StReq) && ack && w_mismatch && (r_errors == 16'd0)) begin
      r_err_addr <= r_addr;
      r_err_data <= rdata;
    end
  end

  assign err_addr = r_err_addr;
  assign err_data = r_err_data;
`else
  assign err_addr = '0;
  assign err_data = '0;
`endif

  assign addr   = r_addr;
  assign req    = r_req;
  assign wr     = 1'b0;
  assign active = r_active;
  assign done   = r_done;
  assign pass   = r_pass;
  assign errors = r_errors;

endmodule

// File: tb/tb_rectverify.sv
// Bench for rectverify: one 4x2 instance with a scoreboarded responder, plus small 1x1 and
// 3x3 instances with zero-wait, all-zero-data responders.
module tb_rectverify;

  localparam int A_BASE = 'h1000;
  localparam int A_LS   = 480;
  localparam int A_XOFF = 2;
  localparam int A_YOFF = 1;
  localparam int A_XLEN = 4;
  localparam int A_YLEN = 2;
  localparam int A_RELOAD = A_BASE + A_YOFF * A_LS + A_XOFF;
  localparam int A_WORDS  = A_XLEN * A_YLEN;

  logic clk;
  logic n_reset;

  logic [23:0] a_addr, a_err_addr, b_addr, b_err_addr, c_addr, c_err_addr;
  logic [15:0] a_rdata, a_errors, a_err_data, b_errors, b_err_data, c_errors, c_err_data;
  logic a_req, a_wr, a_ack, a_start, a_active, a_done, a_pass;
  logic b_req, b_wr, b_ack, b_start, b_active, b_done, b_pass;
  logic c_req, c_wr, c_ack, c_start, c_active, c_done, c_pass;

  int total = 0;
  int bad = 0;
  int n_txn = 0;
  int m_err = 0;
  int inv_idx = -1;
  int wait_cnt = -1;
  int done_cnt = 0;
  int b_reads = 0;
  int c_reads = 0;
  bit rnd_mode = 0;
  bit spur_mode = 0;
  bit chk_en = 0;

  rectverify #(.AN(24), .DN(16), .BASE(A_BASE), .XN(8), .YN(8), .LS(A_LS), .XOFF(A_XOFF),
               .YOFF(A_YOFF), .XLEN(A_XLEN), .YLEN(A_YLEN)) u_a (
    .clkSYS(clk), .n_reset(n_reset), .addr(a_addr), .req(a_req), .wr(a_wr), .ack(a_ack),
    .rdata(a_rdata), .start(a_start), .active(a_active), .done(a_done), .pass(a_pass),
    .errors(a_errors), .err_addr(a_err_addr), .err_data(a_err_data));

  rectverify #(.AN(24), .DN(16), .BASE('h20), .XN(8), .YN(8), .LS(480), .XOFF(0),
               .YOFF(0), .XLEN(1), .YLEN(1)) u_b (
    .clkSYS(clk), .n_reset(n_reset), .addr(b_addr), .req(b_req), .wr(b_wr), .ack(b_ack),
    .rdata(16'h0000), .start(b_start), .active(b_active), .done(b_done), .pass(b_pass),
    .errors(b_errors), .err_addr(b_err_addr), .err_data(b_err_data));

  rectverify #(.AN(24), .DN(16), .BASE(0), .XN(8), .YN(8), .LS(8), .XOFF(1),
               .YOFF(1), .XLEN(3), .YLEN(3)) u_c (
    .clkSYS(clk), .n_reset(n_reset), .addr(c_addr), .req(c_req), .wr(c_wr), .ack(c_ack),
    .rdata(16'h0000), .start(c_start), .active(c_active), .done(c_done), .pass(c_pass),
    .errors(c_errors), .err_addr(c_err_addr), .err_data(c_err_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sequence: word n of the fill pattern is the LFSR after n steps from zero.
  function automatic logic [15:0] exp_word(input int n);
    logic [17:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = {s[16:0], ~s[17] ^ s[10]};
    return s[17:2];
  endfunction

  // Reference address of word n in x-then-y order.
  function automatic logic [23:0] exp_addr(input int n);
    return 24'(A_RELOAD + (n / A_XLEN) * A_LS + (n % A_XLEN));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Responder for u_a: optional random wait states, optional spurious acks, optional bad word.
  initial begin
    a_ack = 1'b0;
    a_rdata = '0;
    forever begin
      @(negedge clk);
      a_ack = 1'b0;
      if (a_req) begin
        if (wait_cnt < 0) wait_cnt = rnd_mode ? int'($urandom_range(0, 5)) : 0;
        if (wait_cnt == 0) begin
          a_ack = 1'b1;
          a_rdata = exp_word(n_txn);
          if (n_txn == inv_idx) begin
            a_rdata = ~a_rdata;
            m_err++;
          end
          n_txn++;
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end else if (spur_mode && ($urandom_range(0, 1) == 1)) begin
        a_ack = 1'b1;
        a_rdata = 16'hDEAD;
      end
    end
  end

  // Zero-wait responders for u_b / u_c (rdata tied to zero).
  initial begin
    b_ack = 1'b0;
    c_ack = 1'b0;
    forever begin
      @(negedge clk);
      b_ack = b_req;
      c_ack = c_req;
      if (b_req) b_reads++;
      if (c_req) c_reads++;
    end
  end

  // Per-cycle compare of u_a against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        check("wr_zero", {31'd0, a_wr}, 0);
        if (a_req) check("addr", {8'd0, a_addr}, {8'd0, exp_addr(n_txn)});
        check("errors_track", {16'd0, a_errors}, m_err);
        if (a_done) begin
          done_cnt++;
          check("done_reads", n_txn, A_WORDS);
          check("done_pass", {31'd0, a_pass}, (m_err == 0) ? 1 : 0);
        end
      end
    end
  end

  task automatic run_pass(input bit rnd, input bit spur, input int inv, input bit extra_start,
                          input int exp_err, input bit exp_pass, output int cyc);
    int d0;
    bit got;
    rnd_mode = rnd;
    spur_mode = spur;
    inv_idx = inv;
    d0 = done_cnt;
    @(negedge clk);
    n_txn = 0;
    m_err = 0;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    check("active_rise", {31'd0, a_active}, 1);
    check("req_rise", {31'd0, a_req}, 1);
    cyc = 0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      a_start = (extra_start && (i == 3)) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (a_done) begin
        got = 1;
        check("active_fall", {31'd0, a_active}, 0);
      end
    end
    a_start = 1'b0;
    check("done_seen", {31'd0, got}, 1);
    check("errors_end", {16'd0, a_errors}, exp_err);
    check("pass_end", {31'd0, a_pass}, {31'd0, exp_pass});
    repeat (6) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("reads", n_txn, A_WORDS);
    check("idle_after", {31'd0, a_active}, 0);
    spur_mode = 0;
    rnd_mode = 0;
  endtask

  initial begin
    int cyc;
    int nz;
    bit got;
    n_reset = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state.
    check("rst_addr", {8'd0, a_addr}, 32'h11E2);
    check("rst_req", {31'd0, a_req}, 0);
    check("rst_wr", {31'd0, a_wr}, 0);
    check("rst_active", {31'd0, a_active}, 0);
    check("rst_done", {31'd0, a_done}, 0);
    check("rst_pass", {31'd0, a_pass}, 0);
    check("rst_errors", {16'd0, a_errors}, 0);
    check("rst_err_addr", {8'd0, a_err_addr}, 0);
    check("rst_err_data", {16'd0, a_err_data}, 0);
    check("rst_addr_b", {8'd0, b_addr}, 32'h20);
    check("rst_addr_c", {8'd0, c_addr}, 32'h9);
    // Pin the model with hand-derived values.
    check("model_w3", {16'd0, exp_word(3)}, 32'h1);
    check("model_w4", {16'd0, exp_word(4)}, 32'h3);
    check("model_w7", {16'd0, exp_word(7)}, 32'h1F);
    check("model_a0", {8'd0, exp_addr(0)}, 32'h11E2);
    check("model_a3", {8'd0, exp_addr(3)}, 32'h11E5);
    check("model_a4", {8'd0, exp_addr(4)}, 32'h13C2);
    check("model_a7", {8'd0, exp_addr(7)}, 32'h13C5);
    n_reset = 1'b1;
    chk_en = 1;

    // Clean zero-wait pass.
    run_pass(0, 0, -1, 0, 0, 1, cyc);
    check("pass_len", cyc, 16);

    // Bad fifth word.
    run_pass(0, 0, 4, 0, 1, 0, cyc);
`ifdef RECTVERIFY_ERRADDR_EN
    check("err_addr", {8'd0, a_err_addr}, 32'h13C2);
    check("err_data", {16'd0, a_err_data}, 32'hFFFC);
    check("err_data_model", {16'd0, a_err_data}, {16'd0, ~exp_word(4)});
`endif

    // Random wait states with spurious acks.
    run_pass(1, 1, -1, 0, 0, 1, cyc);
`ifdef RECTVERIFY_ERRADDR_EN
    check("err_addr_clr", {8'd0, a_err_addr}, 0);
`endif

    // Start pulsed while active.
    run_pass(0, 0, -1, 1, 0, 1, cyc);
    check("pass_len_restart", cyc, 16);

    // Reset during the third read.
    inv_idx = 0;
    rnd_mode = 0;
    @(negedge clk);
    n_txn = 0;
    m_err = 0;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      #1;
      if (a_req && (n_txn == 2)) got = 1;
    end
    check("third_read_seen", {31'd0, got}, 1);
    check("pre_rst_errors", {16'd0, a_errors}, 1);
    chk_en = 0;
    n_reset = 1'b0;
    #1;
    check("abort_req", {31'd0, a_req}, 0);
    check("abort_active", {31'd0, a_active}, 0);
    check("abort_errors", {16'd0, a_errors}, 0);
    check("abort_pass", {31'd0, a_pass}, 0);
    check("abort_addr", {8'd0, a_addr}, 32'h11E2);
    m_err = 0;
    @(negedge clk);
    n_reset = 1'b1;
    inv_idx = -1;
    nz = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (a_done || a_active) nz++;
    end
    check("abort_no_done", nz, 0);
    n_txn = 0;
    chk_en = 1;
    run_pass(0, 0, -1, 0, 0, 1, cyc);
    check("post_abort_len", cyc, 16);

    // 1x1 window.
    @(negedge clk);
    b_reads = 0;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    check("b_active", {31'd0, b_active}, 1);
    check("b_addr", {8'd0, b_addr}, 32'h20);
    cyc = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (b_done) got = 1;
    end
    check("b_done_seen", {31'd0, got}, 1);
    check("b_len", cyc, 2);
    check("b_pass", {31'd0, b_pass}, 1);
    check("b_reads", b_reads, 1);

    // 3x3 window against all-zero data, run twice.
    nz = 0;
    for (int i = 0; i < 9; i++) if (exp_word(i) != 16'd0) nz++;
    check("model_nz", nz, 6);
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      c_reads = 0;
      c_start = 1'b1;
      @(posedge clk);
      #1;
      c_start = 1'b0;
      check("c_errors_cleared", {16'd0, c_errors}, 0);
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk);
        #1;
        if (c_done) got = 1;
      end
      check("c_done_seen", {31'd0, got}, 1);
      check("c_errors", {16'd0, c_errors}, nz);
      check("c_pass", {31'd0, c_pass}, 0);
      check("c_reads", c_reads, 9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rectverify.md
# rectverify

Rectangular memory read-back checker. Reads an XLEN×YLEN window of a line-organised frame buffer over the system memory request/ack bus, one word per transaction. Each word is compared against the 18-bit LFSR data sequence that the rectangular fill block writes. Sits beside the fill block as its reader counterpart, for self-test of the memory path and arbiter, and reports an error count and pass/fail.

## Interface
Parameters:
- AN, 24, address bus width
- DN, 16, data bus width (≤16; expected data is LFSR[17:18-DN])
- BASE, 0, frame base address
- XN, 8, x-counter width (≥ clog2(XLEN))
- YN, 8, y-counter width (≥ clog2(YLEN))
- LS, 480, line stride in words
- XOFF, 0, window x offset
- YOFF, 0, window y offset
- XLEN, 16, window width in words (≥1)
- YLEN, 16, window height in lines (≥1)

Ports:
- clkSYS  in  1  system clock
- n_reset  in  1  reset; asynchronous, active-low
- addr  out  AN  read address
- req  out  1  read request, registered
- wr  out  1  constant 0
- ack  in  1  responder accept; rdata valid in the same cycle
- rdata  in  DN  read data
- start  in  1  single-cycle start
- active  out  1  pass in progress
- done  out  1  one-cycle pulse at pass end
- pass  out  1  last pass had zero errors
- errors  out  16  mismatch count, saturating
- err_addr  out  AN  address of first mismatch
- err_data  out  DN  rdata of first mismatch

## Operation
- RELOAD = BASE + YOFF*LS + XOFF, evaluated modulo 2^AN.
- The word at (x,y) is read at addr = RELOAD + y*LS + x.
- Traversal order: x ascending, then y ascending.
- Address generation is incremental:
  - A line-base register holds the first address of the current line.
  - At end of line, line-base += LS and addr ← new line-base.
  - Otherwise addr += 1.
  - All arithmetic wraps modulo 2^AN.
- LFSR: 18 bits, shift left, feedback bit = ~lfsr[17] ^ lfsr[10].
  - Cleared to 0 on start.
  - Advances once per completed word.
  - Expected data = lfsr[17:18-DN].
- FSM states are IDLE, REQ, NEXT.
  - IDLE: on start, go to REQ. Clear errors, pass, err_addr and err_data. Set addr ← RELOAD, line-base ← RELOAD, x=y=0, lfsr=0, active ← 1, req ← 1.
  - REQ: req held high until ack is sampled high. On ack: req ← 0, compare rdata with expected, go to NEXT.
  - On mismatch: errors += 1, saturating at 0xFFFF. If errors was 0, capture err_addr ← addr and err_data ← rdata.
  - NEXT: advance x/y, addr and lfsr.
    - If the word was (XLEN-1, YLEN-1): active ← 0, done ← 1 for one cycle, pass ← (errors==0), go to IDLE.
    - Otherwise: req ← 1, go to REQ.
- start while active is ignored.
- ack while req=0 is ignored.
- addr is stable while req=1.
- Reset values: addr=RELOAD, req=0, wr=0, active=0, done=0, pass=0, errors=0, err_addr=0, err_data=0, state IDLE.
- Asserting n_reset mid-pass aborts the pass immediately: req drops asynchronously and no done pulse is generated.

## Timing
- Start is sampled at edge T. active=1, req=1 and addr=RELOAD are visible from T+1.
- If ack is high in cycle k:
  - req is low in cycle k+1 (NEXT).
  - The errors update is visible in k+1.
  - The next address is visible in k+2 with req=1.
- Zero-wait responder: ack first asserted in req's first cycle. This gives 2 cycles per word and total pass length 2*XLEN*YLEN cycles from T+1 to the done pulse.
- done and the final pass value appear in the same cycle; active falls in that cycle.
- A new start is accepted at the edge after done.

## Configuration
- RECTVERIFY_ERRADDR_EN defined: the err_addr/err_data capture registers are built and behave as described above.
- Not defined: err_addr and err_data are constant 0 and no capture registers exist. All other behaviour is unchanged.

## Test plan
- Use XLEN=4, YLEN=2, LS=480, BASE=0x1000, XOFF=2, YOFF=1 (RELOAD=0x11E2). Zero-wait responder returns the model LFSR data.
  - Required address sequence: 11E2, 11E3, 11E4, 11E5, 13C2, 13C3, 13C4, 13C5.
  - done arrives 16 cycles after active rises, with pass=1 and errors=0.
- Responder inverts rdata on the 5th word -> errors=1, pass=0, err_addr=0x13C2, err_data = ~expected. Check the latter two only with RECTVERIFY_ERRADDR_EN.
- Random 0–5 cycle ack delays, plus spurious ack pulses while req=0:
  - addr stays stable while req=1.
  - Exactly 8 transactions occur.
  - Result is the same as the first scenario.
- start pulsed while active -> ignored; still exactly 8 reads and one done pulse.
- n_reset asserted during the 3rd read:
  - req, active, errors and pass go to 0 immediately and addr goes to RELOAD.
  - A following start runs a clean full pass.
- XLEN=1, YLEN=1 -> a single read at RELOAD, done 2 cycles after active rises.
- Responder returns all-zero data for a 3×3 window -> errors equals the count of nonzero expected words; a second start clears errors to 0 before counting again.
